video_in_2_stream: RTL and testbench

VIDEO_IN_2_STREAM -- requirements
Module: video_in_2_stream

---
 rtl/video_in_2_stream.sv | 183 ++++++++++++++++++
 tb/tb_video_in_2_stream.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_in_2_stream.sv
// Video capture front end: registers RGB565 video timing inputs, frames pixels by
// vsync/active_video and pushes them through a small FIFO onto a valid/ready stream.
module video_in_2_stream #(
    parameter int H_ACTIVE   = 800,
    parameter int FIFO_DEPTH = 16,
    parameter bit HSYNC_POL  = 1'b0,
    parameter bit VSYNC_POL  = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        capture_en,
    input  logic [4:0]  video_r,
    input  logic [5:0]  video_g,
    input  logic [4:0]  video_b,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        active_video,
    output logic [15:0] sdata,
    output logic        svalid,
    input  logic        sready,
    output logic        sframe,
    output logic        sline_end,
    output logic        overflow,
    input  logic        overflow_clr,
    output logic [15:0] frame_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);

    if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 4");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DROP    = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Stage p0: input registers; nothing downstream sees the raw video pins.
    logic [4:0] r_p0;
    logic [5:0] g_p0;
    logic [4:0] b_p0;
    logic       hsync_act_p0;
    logic       vld_p0;
    logic       vsync_act_p0;

    always_ff @(posedge clk) begin
        r_p0         <= video_r;
        g_p0         <= video_g;
        b_p0         <= video_b;
        hsync_act_p0 <= (hsync == HSYNC_POL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0       <= 1'b0;
            vsync_act_p0 <= 1'b0;
        end else begin
            vld_p0       <= active_video;
            vsync_act_p0 <= (vsync == VSYNC_POL);
        end
    end

    // hsync is captured for timing visibility only; lines are delimited by active_video.
    logic unused_hsync;
    assign unused_hsync = hsync_act_p0;

    // Stage p1: previous registered controls for edge detection.
    logic vld_p1;
    logic vsync_act_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1       <= 1'b0;
            vsync_act_p1 <= 1'b0;
        end else begin
            vld_p1       <= vld_p0;
            vsync_act_p1 <= vsync_act_p0;
        end
    end

    logic boundary;
    assign boundary = vsync_act_p0 && !vsync_act_p1;

    // Column counter runs in every state so line alignment survives IDLE/DROP.
    logic [XW-1:0] x;
    logic          line_last;
    assign line_last = (x == X_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            x <= '0;
        end else if (boundary) begin
            x <= '0;
        end else if (vld_p0) begin
            x <= line_last ? '0 : x + XW'(1);
        end else if (vld_p1) begin
            x <= '0;
        end
    end

    // FIFO occupancy; the extra pointer bit separates full from empty.
    logic [AW:0]  wr_ptr, rd_ptr, fill;
    logic         full, empty;
    logic [17:0]  mem [FIFO_DEPTH];
    logic         wr_en, rd_en, ovf_set, frame_inc, sof_arm, sof_pend;

    assign fill  = wr_ptr - rd_ptr;
    assign full  = fill[AW];
    assign empty = (fill == '0);

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        ovf_set   = 1'b0;
        frame_inc = 1'b0;
        case (state)
            IDLE: begin
                if (boundary && capture_en) state_nxt = CAPTURE;
            end
            CAPTURE: begin
                // A full FIFO refuses the write even if a read drains it this cycle.
                if (vld_p0) begin
                    if (full) begin
                        ovf_set   = 1'b1;
                        state_nxt = DROP;
                    end else begin
                        wr_en = 1'b1;
                    end
                end
                if (boundary) begin
                    frame_inc = 1'b1;
                    state_nxt = capture_en ? CAPTURE : IDLE;
                end
            end
            DROP: begin
                if (boundary) state_nxt = capture_en ? CAPTURE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign sof_arm = boundary && (state_nxt == CAPTURE);
    assign rd_en   = svalid && sready;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Stage p2: FIFO write; entry is {pixel, first-of-frame, last-of-line}.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= {r_p0, b_p0, g_p0, sof_pend, line_last};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            sof_pend    <= 1'b0;
            overflow    <= 1'b0;
            frame_count <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
            if (sof_arm)    sof_pend <= 1'b1;
            else if (wr_en) sof_pend <= 1'b0;
            if (ovf_set)           overflow <= 1'b1;
            else if (overflow_clr) overflow <= 1'b0;
            if (frame_inc) frame_count <= frame_count + 16'd1;
        end
    end

    // Stream side: head entry is presented directly, zeroed while empty.
    assign svalid = !empty;
    assign {sdata, sframe, sline_end} = svalid ? mem[rd_ptr[AW-1:0]] : 18'd0;

endmodule

// File: tb/tb_video_in_2_stream.sv
// Bench for video_in_2_stream: directed scenarios plus randomized frames, checked
// cycle by cycle against a frame-level queue model of the capture path.
module tb_video_in_2_stream;

    localparam int H     = 4;
    localparam int DEPTH = 4;
    localparam bit VPOL  = 1'b0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        capture_en = 1'b0;
    logic [4:0]  video_r = '0;
    logic [5:0]  video_g = '0;
    logic [4:0]  video_b = '0;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic        active_video = 1'b0;
    logic [15:0] sdata;
    logic        svalid;
    logic        sready = 1'b0;
    logic        sframe;
    logic        sline_end;
    logic        overflow;
    logic        overflow_clr = 1'b0;
    logic [15:0] frame_count;

    always #5 clk = ~clk;

    video_in_2_stream #(
        .H_ACTIVE(H), .FIFO_DEPTH(DEPTH), .HSYNC_POL(1'b0), .VSYNC_POL(VPOL)
    ) dut (
        .clk(clk), .reset(reset), .capture_en(capture_en),
        .video_r(video_r), .video_g(video_g), .video_b(video_b),
        .hsync(hsync), .vsync(vsync), .active_video(active_video),
        .sdata(sdata), .svalid(svalid), .sready(sready),
        .sframe(sframe), .sline_end(sline_end),
        .overflow(overflow), .overflow_clr(overflow_clr),
        .frame_count(frame_count)
    );

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;
    int first_pix = -1;
    int first_sv  = -1;

    logic cen_g = 1'b0;
    logic oclr_g = 1'b0;
    int   rdy_mode = 1;
    logic tog = 1'b0;

    // Model: expected FIFO contents plus frame-level capture status.
    logic [17:0] q[$];
    logic [17:0] got[$];
    int          m_mode = 0;
    logic        m_sof = 1'b0, m_ovf = 1'b0;
    logic [15:0] m_fc = '0;
    logic        m_vs1 = 1'b0, m_vs2 = 1'b0, m_av1 = 1'b0, m_le1 = 1'b0;
    logic [15:0] m_pix1 = '0;
    logic        prev_stall = 1'b0;
    logic [17:0] prev_out = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic av, input logic vs, input logic [15:0] pix, input logic le);
        logic        rdy, bnd, wr, ovf_evt, full;
        logic [17:0] out, entry;
        int          mode0;
        cyc_n++;
        case (rdy_mode)
            0: rdy = 1'b0;
            1: rdy = 1'b1;
            2: begin tog = ~tog; rdy = tog; end
            default: rdy = 1'($urandom_range(0, 1));
        endcase
        active_video = av;
        vsync = vs ? VPOL : ~VPOL;
        {video_r, video_b, video_g} = pix;
        hsync = 1'($urandom_range(0, 1));
        sready = rdy;
        capture_en = cen_g;
        overflow_clr = oclr_g;
        if (av && first_pix < 0) first_pix = cyc_n;
        @(negedge clk);
        out = {sdata, sframe, sline_end};
        chk("svalid", 32'(svalid), 32'(q.size() != 0));
        if (q.size() != 0) chk("payload", 32'(out), 32'(q[0]));
        if (prev_stall) chk("stall_hold", 32'({svalid, out}), 32'({1'b1, prev_out}));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("frame_count", 32'(frame_count), 32'(m_fc));
        if (svalid && first_sv < 0) first_sv = cyc_n;
        if (svalid && rdy) got.push_back(out);
        prev_stall = svalid && !rdy;
        prev_out = out;
        // Advance the model over the coming clock edge.
        mode0 = m_mode;
        bnd = m_vs1 && !m_vs2;
        full = (q.size() == DEPTH);
        wr = 1'b0;
        ovf_evt = 1'b0;
        entry = {m_pix1, m_sof, m_le1};
        if (m_mode == 1 && m_av1) begin
            if (full) begin ovf_evt = 1'b1; m_mode = 2; end
            else wr = 1'b1;
        end
        if (wr) m_sof = 1'b0;
        if (bnd) begin
            if (mode0 == 1) m_fc = m_fc + 16'd1;
            m_mode = cen_g ? 1 : 0;
            if (cen_g) m_sof = 1'b1;
        end
        if (q.size() != 0 && rdy) void'(q.pop_front());
        if (wr) q.push_back(entry);
        if (ovf_evt) m_ovf = 1'b1;
        else if (oclr_g) m_ovf = 1'b0;
        m_vs2 = m_vs1; m_vs1 = vs; m_av1 = av; m_pix1 = pix; m_le1 = le;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        active_video = 1'b0;
        vsync = ~VPOL;
        sready = 1'b0;
        overflow_clr = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        cyc_n++;
        q.delete();
        got.delete();
        m_mode = 0; m_sof = 1'b0; m_ovf = 1'b0; m_fc = '0;
        m_vs1 = 1'b0; m_vs2 = 1'b0; m_av1 = 1'b0; m_le1 = 1'b0;
        prev_stall = 1'b0;
        chk("rst_svalid", 32'(svalid), 32'd0);
        chk("rst_payload", 32'({sdata, sframe, sline_end}), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic vsync_pulse();
        cyc(1'b0, 1'b0, 16'h0, 1'b0);
        cyc(1'b0, 1'b1, 16'h0, 1'b0);
        cyc(1'b0, 1'b1, 16'h0, 1'b0);
        cyc(1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic line(input logic [15:0] start, input int len, input int gap);
        for (int i = 0; i < len; i++) cyc(1'b1, 1'b0, 16'(start + 16'(i)), (i % H) == H - 1);
        idle(gap);
    endtask

    initial begin
        // Two lines with a free-running sink.
        do_reset();
        cen_g = 1'b1; rdy_mode = 1;
        vsync_pulse();
        first_pix = -1; first_sv = -1;
        line(16'h0001, 4, 2);
        line(16'h0005, 4, 2);
        idle(6);
        chk("s1_count", 32'(got.size()), 32'd8);
        for (int i = 0; i < 8 && i < got.size(); i++)
            chk("s1_entry", 32'(got[i]), 32'({16'(i + 1), i == 0, (i == 3) || (i == 7)}));
        chk("s1_latency", 32'(first_sv - first_pix), 32'd2);

        // Stalled sink: FIFO fills, fifth pixel overflows, rest of frame dropped.
        do_reset();
        cen_g = 1'b1; rdy_mode = 0;
        vsync_pulse();
        line(16'h0001, 4, 2);
        line(16'h0005, 4, 2);
        chk("s2_overflow", 32'(overflow), 32'd1);
        chk("s2_no_xfer", 32'(got.size()), 32'd0);
        rdy_mode = 1;
        idle(8);
        line(16'h0009, 4, 4);
        chk("s2_count", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4 && i < got.size(); i++)
            chk("s2_entry", 32'(got[i][17:2]), 32'(i + 1));

        // Toggling sink.
        do_reset();
        cen_g = 1'b1; rdy_mode = 2; tog = 1'b0;
        vsync_pulse();
        line(16'h0001, 4, 10);
        chk("s3_count", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4 && i < got.size(); i++)
            chk("s3_entry", 32'(got[i][17:2]), 32'(i + 1));

        // Capture disabled.
        do_reset();
        cen_g = 1'b0; rdy_mode = 1;
        vsync_pulse();
        line(16'h0021, 4, 4);
        chk("s4_no_xfer", 32'(got.size()), 32'd0);
        vsync_pulse();
        chk("s4_frame_count", 32'(frame_count), 32'd0);

        // Reset mid-frame.
        do_reset();
        cen_g = 1'b1; rdy_mode = 1;
        vsync_pulse();
        cyc(1'b1, 1'b0, 16'h0001, 1'b0);
        cyc(1'b1, 1'b0, 16'h0002, 1'b0);
        do_reset();
        cyc(1'b1, 1'b0, 16'h0003, 1'b0);
        cyc(1'b1, 1'b0, 16'h0004, 1'b1);
        idle(2);
        line(16'h0005, 4, 3);
        chk("s5_ignored", 32'(got.size()), 32'd0);
        vsync_pulse();
        line(16'h0011, 4, 4);
        chk("s5_count", 32'(got.size()), 32'd4);
        if (got.size() > 0) chk("s5_first", 32'(got[0]), 32'({16'h0011, 1'b1, 1'b0}));

        // Overflow set and clear in the same cycle, then a plain clear.
        do_reset();
        cen_g = 1'b1; rdy_mode = 0;
        vsync_pulse();
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 16'(i + 1), i == 3);
        oclr_g = 1'b1;
        cyc(1'b1, 1'b0, 16'h0006, 1'b0);
        oclr_g = 1'b0;
        chk("s6_set_wins", 32'(overflow), 32'd1);
        idle(1);
        oclr_g = 1'b1;
        idle(1);
        oclr_g = 1'b0;
        chk("s6_cleared", 32'(overflow), 32'd0);

        // Three completed frames.
        do_reset();
        cen_g = 1'b1; rdy_mode = 1;
        for (int f = 0; f < 3; f++) begin
            vsync_pulse();
            line(16'(16'h0100 * (f + 1)), 4, 2);
        end
        vsync_pulse();
        idle(4);
        chk("s6_frames", 32'(frame_count), 32'd3);
        chk("s6_xfers", 32'(got.size()), 32'd12);

        // Randomized frames against the model.
        do_reset();
        for (int f = 0; f < 40; f++) begin
            cen_g = ($urandom_range(0, 3) != 0);
            rdy_mode = $urandom_range(0, 3);
            oclr_g = ($urandom_range(0, 3) == 0);
            vsync_pulse();
            oclr_g = 1'b0;
            for (int l = 0; l < $urandom_range(1, 3); l++)
                line(16'($urandom), $urandom_range(1, 7), $urandom_range(1, 3));
        end
        rdy_mode = 1;
        idle(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
